// File: rtl/writeback_queue.sv
// Writeback queue: merges up to two producer results per cycle into an
// ordered buffer that drains through two register-file write ports.
module writeback_queue #(
    parameter int SIZE           = 32,
    parameter int REGISTER_COUNT = 31,
    parameter int SOURCE_COUNT   = 4,
    parameter int DEPTH          = 8,
    localparam int IW            = $clog2(REGISTER_COUNT),
    localparam int PW            = $clog2(DEPTH),
    localparam int CW            = PW + 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [SOURCE_COUNT-1:0]             source_valid,
    input  logic [SOURCE_COUNT-1:0][IW-1:0]     source_index,
    input  logic [SOURCE_COUNT-1:0][SIZE-1:0]   source_data,
    output logic [SOURCE_COUNT-1:0]             source_ready,
    output logic [1:0]                          write_enable,
    output logic [1:0][IW-1:0]                  write_index,
    output logic [1:0][SIZE-1:0]                write_data,
    output logic [REGISTER_COUNT-1:0]           pending,
    output logic [CW-1:0]                       count
);

    logic [IW-1:0]   mem_index [DEPTH];
    logic [SIZE-1:0] mem_data  [DEPTH];

    logic [PW-1:0] head, tail, head_next;
    logic [CW-1:0] count_q, space;
    logic [1:0]    limit, n_acc, n_iss;
    logic [IW-1:0]   e0_index, e1_index;
    logic [SIZE-1:0] e0_data, e1_data;
    logic [REGISTER_COUNT-1:0] pending_c;
    logic we0, we1;

    assign space = CW'(DEPTH) - count_q;
    assign limit = (space >= CW'(2)) ? 2'd2 : space[1:0];

    // Fixed priority grant; at most 'limit' lowest valid sources accepted.
    always_comb begin
        logic [1:0] seen;
        seen         = '0;
        n_acc        = '0;
        source_ready = '0;
        e0_index     = '0;
        e0_data      = '0;
        e1_index     = '0;
        e1_data      = '0;
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            source_ready[i] = !reset && (seen < limit);
            if (source_valid[i] && source_ready[i]) begin
                if (n_acc == 2'd0) begin
                    e0_index = source_index[i];
                    e0_data  = source_data[i];
                end else begin
                    e1_index = source_index[i];
                    e1_data  = source_data[i];
                end
                n_acc = n_acc + 2'd1;
            end
            if (source_valid[i] && seen < 2'd2)
                seen = seen + 2'd1;
        end
    end

    assign head_next = head + PW'(1);
    assign we0 = !reset && (count_q >= CW'(1));
    assign we1 = !reset && (count_q >= CW'(2))
                 && (mem_index[head_next] != mem_index[head]);
    assign n_iss = {1'b0, we0} + {1'b0, we1};

    assign write_enable   = {we1, we0};
    assign write_index[0] = we0 ? mem_index[head] : '0;
    assign write_data[0]  = we0 ? mem_data[head] : '0;
    assign write_index[1] = we1 ? mem_index[head_next] : '0;
    assign write_data[1]  = we1 ? mem_data[head_next] : '0;
    assign count          = reset ? '0 : count_q;

    always_comb begin
        logic [PW-1:0] off;
        pending_c = '0;
        for (int s = 0; s < DEPTH; s++) begin
            off = PW'(s) - head;
            if (CW'(off) < count_q) begin
                for (int j = 0; j < REGISTER_COUNT; j++) begin
                    if (mem_index[s] == IW'(j))
                        pending_c[j] = 1'b1;
                end
            end
        end
    end

    assign pending = reset ? '0 : pending_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PW'(n_iss);
            tail    <= tail + PW'(n_acc);
            count_q <= count_q + CW'(n_acc) - CW'(n_iss);
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clock) begin
        if (n_acc != 2'd0) begin
            mem_index[tail] <= e0_index;
            mem_data[tail]  <= e0_data;
        end
        if (n_acc == 2'd2) begin
            mem_index[tail + PW'(1)] <= e1_index;
            mem_data[tail + PW'(1)]  <= e1_data;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue.
module tb_writeback_queue;

    localparam int SIZE = 32;
    localparam int RC   = 31;
    localparam int SC   = 4;
    localparam int IW   = 5;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [SC-1:0]            source_valid;
    logic [SC-1:0][IW-1:0]    source_index;
    logic [SC-1:0][SIZE-1:0]  source_data;
    logic [SC-1:0]            source_ready;
    logic [1:0]               write_enable;
    logic [1:0][IW-1:0]       write_index;
    logic [1:0][SIZE-1:0]     write_data;
    logic [RC-1:0]            pending;
    logic [3:0]               count;

    int total = 0;
    int bad   = 0;

    writeback_queue dut (
        .clock        (clock),
        .reset        (reset),
        .source_valid (source_valid),
        .source_index (source_index),
        .source_data  (source_data),
        .source_ready (source_ready),
        .write_enable (write_enable),
        .write_index  (write_index),
        .write_data   (write_data),
        .pending      (pending),
        .count        (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        source_valid = '0;
        source_index = '0;
        source_data  = '0;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        idle();
        source_valid = 4'hF;
        step();
        step();
        #1;
        check("rst_ready", 64'(source_ready), 0);
        check("rst_we", 64'(write_enable), 0);
        check("rst_pend", 64'(pending), 0);
        check("rst_count", 64'(count), 0);
        reset = 1'b0;
        idle();
        step();

        // two sparse sources on empty queue
        source_valid    = 4'b0101;
        source_index[0] = 5'd5;
        source_data[0]  = 32'h11;
        source_index[2] = 5'd7;
        source_data[2]  = 32'h22;
        #1;
        check("t1_ready", 64'(source_ready), 64'b0111);
        step();
        idle();
        #1;
        check("t1_count", 64'(count), 2);
        check("t1_we", 64'(write_enable), 2'b11);
        check("t1_wi0", 64'(write_index[0]), 5);
        check("t1_wd0", 64'(write_data[0]), 32'h11);
        check("t1_wi1", 64'(write_index[1]), 7);
        check("t1_wd1", 64'(write_data[1]), 32'h22);
        check("t1_pend", 64'(pending), (64'd1 << 5) | (64'd1 << 7));
        step();
        #1;
        check("t1_count0", 64'(count), 0);
        check("t1_we0", 64'(write_enable), 0);
        check("t1_wi_z", 64'(write_index), 0);

        // same register twice must issue in order, one per cycle
        source_valid    = 4'b0011;
        source_index[0] = 5'd3;
        source_data[0]  = 32'hA;
        source_index[1] = 5'd3;
        source_data[1]  = 32'hB;
        #1;
        check("t2_ready", 64'(source_ready), 64'b0011);
        step();
        idle();
        #1;
        check("t2_count", 64'(count), 2);
        check("t2_we", 64'(write_enable), 2'b01);
        check("t2_wi0", 64'(write_index[0]), 3);
        check("t2_wd0", 64'(write_data[0]), 32'hA);
        check("t2_wd1", 64'(write_data[1]), 0);
        check("t2_pend", 64'(pending), 64'd1 << 3);
        step();
        #1;
        check("t2_count1", 64'(count), 1);
        check("t2_wd0b", 64'(write_data[0]), 32'hB);
        check("t2_pend1", 64'(pending), 64'd1 << 3);
        step();
        #1;
        check("t2_pend0", 64'(pending), 0);

        // all sources valid: only 0 and 1 granted, full throughput
        for (c = 0; c < 5; c++) begin
            source_valid = 4'hF;
            for (int i = 0; i < SC; i++) begin
                source_index[i] = (i < 2) ? IW'(2 * c + 1 + i) : 5'd20;
                source_data[i]  = 32'(c * 16 + i);
            end
            #1;
            check("t3_ready", 64'(source_ready), 64'b0011);
            check("t3_count", 64'(count), (c == 0) ? 0 : 2);
            if (c > 0) begin
                check("t3_we", 64'(write_enable), 2'b11);
                check("t3_wi0", 64'(write_index[0]), 2 * (c - 1) + 1);
                check("t3_wd0", 64'(write_data[0]), (c - 1) * 16);
                check("t3_wi1", 64'(write_index[1]), 2 * (c - 1) + 2);
                check("t3_wd1", 64'(write_data[1]), (c - 1) * 16 + 1);
            end
            step();
        end
        idle();
        #1;
        check("t3_last", 64'(write_data[1]), 4 * 16 + 1);
        step();
        #1;
        check("t3_empty", 64'(count), 0);

        // fill to 7 with duplicate indices so only one issues per cycle
        for (c = 0; c < 6; c++) begin
            source_valid    = 4'b0011;
            source_index[0] = 5'd9;
            source_index[1] = 5'd9;
            source_data[0]  = 32'(2 * c);
            source_data[1]  = 32'(2 * c + 1);
            #1;
            check("t4_ready", 64'(source_ready), 64'b0011);
            check("t4_count", 64'(count), (c == 0) ? 0 : c + 1);
            if (c > 0) begin
                check("t4_we", 64'(write_enable), 2'b01);
                check("t4_wd0", 64'(write_data[0]), c - 1);
            end
            step();
        end
        idle();
        source_valid    = 4'b1010;
        source_index[1] = 5'd9;
        source_data[1]  = 32'h77;
        source_index[3] = 5'd9;
        source_data[3]  = 32'h88;
        #1;
        check("t4_cnt7", 64'(count), 7);
        check("t4_one", 64'(source_ready), 64'b0011);
        check("t4_wd0_7", 64'(write_data[0]), 5);
        step();
        idle();
        #1;
        check("t4_cnt7b", 64'(count), 7);
        c = 0;
        while (count != 0 && c < 20) begin
            step();
            c++;
        end
        #1;
        check("t4_drain", 64'(count), 0);
        check("t4_pend", 64'(pending), 0);

        // alternating single enqueue/dequeue wraps the pointers
        for (int k = 0; k < 20; k++) begin
            source_valid    = 4'b0100;
            source_index[2] = IW'(k % 30 + 1);
            source_data[2]  = 32'(32'h100 + k);
            #1;
            check("t5_ready", 64'(source_ready[2]), 1);
            step();
            idle();
            #1;
            check("t5_we", 64'(write_enable), 2'b01);
            check("t5_wi0", 64'(write_index[0]), k % 30 + 1);
            check("t5_wd0", 64'(write_data[0]), 32'h100 + k);
            step();
        end
        #1;
        check("t5_empty", 64'(count), 0);

        // reset with five entries queued
        for (c = 0; c < 4; c++) begin
            source_valid    = 4'b0011;
            source_index[0] = 5'd9;
            source_index[1] = 5'd9;
            source_data[0]  = 32'(c);
            source_data[1]  = 32'(c);
            step();
        end
        #1;
        check("t6_cnt5", 64'(count), 5);
        reset = 1'b1;
        #1;
        check("t6_rdy_rst", 64'(source_ready), 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        check("t6_count", 64'(count), 0);
        check("t6_we", 64'(write_enable), 0);
        check("t6_pend", 64'(pending), 0);
        source_valid    = 4'b0001;
        source_index[0] = 5'd4;
        source_data[0]  = 32'h55;
        #1;
        check("t6_ready", 64'(source_ready), 64'hF);
        step();
        idle();
        #1;
        check("t6_we1", 64'(write_enable), 2'b01);
        check("t6_wi0", 64'(write_index[0]), 4);
        check("t6_wd0", 64'(write_data[0]), 32'h55);
        check("t6_pend4", 64'(pending), 64'd1 << 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter SIZE, default 32, register data width in bits.
REQ-002 SHALL have parameter REGISTER_COUNT, default 31, number of architectural registers addressed (IW = $clog2(REGISTER_COUNT) index bits).
REQ-003 SHALL have parameter SOURCE_COUNT, default 4, number of result producers.
REQ-004 SHALL have parameter DEPTH, default 8, power of two, number of queue entries.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port source_valid  input  1 x SOURCE_COUNT  producer i presents a result.
REQ-008 SHALL have port source_index  input  IW x SOURCE_COUNT  destination register of producer i.
REQ-009 SHALL have port source_data  input  SIZE x SOURCE_COUNT  result value of producer i.
REQ-010 SHALL have port source_ready  output  1 x SOURCE_COUNT  producer i result accepted this cycle when source_valid is also high.
REQ-011 SHALL have port write_enable  output  1 x 2  register-file write port enable.
REQ-012 SHALL have port write_index  output  IW x 2  register-file write port index.
REQ-013 SHALL have port write_data  output  SIZE x 2  register-file write port data.
REQ-014 SHALL have port pending  output  1 x REGISTER_COUNT  register j targeted by at least one queued entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-016 SHALL store entries {index, data} in a circular buffer with head and tail pointers wrapping modulo DEPTH, preserving acceptance order.
REQ-017 SHALL compute grant limit L = min(2, DEPTH - count) from the registered count only (same-cycle dequeue does not free space).
REQ-018 SHALL assert source_ready[i] iff fewer than L sources with index below i have source_valid high (fixed priority, lowest index first).
REQ-019 SHALL enqueue each accepted (valid and ready) result at the rising edge, lower source index written first (closer to head).
REQ-020 SHALL drive write port 0 with the head entry, write_enable[0] = (count >= 1).
REQ-021 SHALL drive write port 1 with head+1 entry, write_enable[1] = (count >= 2) and its index differs from the head entry's index.
REQ-022 SHALL never assert both write enables with equal write_index (older write to a register always issues strictly before a younger one).
REQ-023 SHALL dequeue every entry whose write_enable is high at that rising edge (register file accepts unconditionally).
REQ-024 SHALL update count = count + accepted - issued each cycle; simultaneous enqueue and dequeue permitted at full and empty.
REQ-025 SHALL impose one-cycle minimum latency: an entry accepted at edge N appears on a write port no earlier than the cycle following edge N (no bypass).
REQ-026 SHALL drive write_index/write_data to 0 when the corresponding write_enable is low.
REQ-027 SHALL derive pending combinationally from valid queue entries only; an entry being issued keeps its bit high until the edge that dequeues it.
REQ-028 SHALL, at count == DEPTH, drive all source_ready low; at count == DEPTH-1, accept at most one result.

Reset
REQ-029 SHALL, while reset is high, set head = tail = 0, count = 0, and hold source_ready, write_enable, pending all 0.
REQ-030 SHALL discard all queued entries and any same-cycle handshake when reset asserts mid-operation; entry data need not be cleared.

Verification
REQ-031 Sources 0,2 valid (x5=0x11, x7=0x22) on empty queue -> both ready; next cycle write0 x5=0x11, write1 x7=0x22, count 2 then 0.
REQ-032 Queue holds x3=0xA then x3=0xB -> cycle 1 only write0 x3=0xA; cycle 2 write0 x3=0xB; pending[3] high until second dequeue.
REQ-033 All four sources valid every cycle, no drain interference -> exactly sources 0,1 ready each cycle; sources 2,3 never ready; no entry loss.
REQ-034 Fill to count 7 with write side producing duplicate indices, then sources 1,3 valid -> only source 1 ready; count never exceeds 8.
REQ-035 Pointer wrap: 20 alternating enqueue/dequeue pairs -> write order matches accept order across head/tail wrap past 7->0.
REQ-036 Reset asserted with count 5 -> next cycle count 0, write_enable 0, pending all 0; new result accepted normally after release.
